phase_enable_gen: RTL

Parametrised successor to the fixed divide-by-2/divide-by-4 clock scheme used at the processor top level. From the single fast `clock`, generates N_CH independent clock-enable strobes and 50%-style divided clock-shaped outputs, each with a programmable divide ratio and phase offset. Supports run, stall and single-step modes so imem, dmem, regfile and processor can be sequenced from one clock domain. Sits beside the top-level wrapper and feeds per-unit enables instead of gated or derived clocks.

---
 rtl/clk_gen_pkg.sv | 12 +
 rtl/phase_channel.sv | 85 ++++++++
 rtl/phase_enable_gen.sv | 50 +++++
 3 files changed

// File: rtl/clk_gen_pkg.sv
// Shared defaults and the per-channel configuration record for phase_enable_gen.
package clk_gen_pkg;

  localparam int DIV_W_DEF       = 8;
  localparam int DIV_DEFAULT_DEF = 4;

  typedef struct packed {
    logic [DIV_W_DEF-1:0] div;
    logic [DIV_W_DEF-1:0] phase;
  } ch_cfg_t;

endpackage

// File: rtl/phase_channel.sv
// One divider channel: tick counter, clamped phase compare and registered
// strobe / square-wave outputs.
module phase_channel
  import clk_gen_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DIV_DEFAULT = DIV_DEFAULT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             advance,
  input  logic             resync,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  input  logic [DIV_W-1:0] load_phase,
  output logic             en,
  output logic             clk_out
);

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_DEFAULT);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] ZERO    = DIV_W'(0);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] phase_q, phase_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             clk_out_q, clk_out_d;
  logic [DIV_W-1:0] last_s;
  logic [DIV_W-1:0] phase_eff_s;

  assign last_s      = div_q - ONE;
  assign phase_eff_s = (phase_q > last_s) ? last_s : phase_q;

  // Next-state: config load and resync clear override counting; div=0 parks the channel.
  always_comb begin
    div_d     = div_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    en_d      = 1'b0;
    clk_out_d = clk_out_q;
    if (load) begin
      div_d   = load_div;
      phase_d = load_phase;
    end else begin
      div_d   = div_q;
      phase_d = phase_q;
    end
    if (resync || load) begin
      cnt_d     = ZERO;
      clk_out_d = 1'b0;
    end else if (div_q == ZERO) begin
      cnt_d     = ZERO;
      clk_out_d = 1'b0;
    end else if (advance) begin
      cnt_d     = (cnt_q == last_s) ? ZERO : (cnt_q + ONE);
      en_d      = (cnt_q == phase_eff_s);
      clk_out_d = (cnt_q < (div_q >> 1));
    end else begin
      cnt_d     = cnt_q;
      clk_out_d = clk_out_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_q     <= DIV_RST;
      phase_q   <= ZERO;
      cnt_q     <= ZERO;
      en_q      <= 1'b0;
      clk_out_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      en_q      <= en_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign en      = en_q;
  assign clk_out = clk_out_q;

endmodule

// File: rtl/phase_enable_gen.sv
// Multi-channel enable-strobe generator: decodes configuration writes and fans
// out advance/resync to N_CH independent phase_channel instances.
module phase_enable_gen
  import clk_gen_pkg::*;
#(
  parameter int  N_CH        = 4,
  parameter int  DIV_W       = DIV_W_DEF,
  parameter int  DIV_DEFAULT = DIV_DEFAULT_DEF,
  localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             resync,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DIV_W-1:0] cfg_phase,
  output logic [N_CH-1:0]  en,
  output logic [N_CH-1:0]  clk_out
);

  logic advance_s;

  // step while running is absorbed: one tick per edge at most.
  assign advance_s = run | step;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic load_s;
    // Selects beyond N_CH never match, so out-of-range writes are dropped.
    assign load_s = cfg_we && (cfg_ch == CH_W'(i));

    phase_channel #(
      .DIV_W       (DIV_W),
      .DIV_DEFAULT (DIV_DEFAULT)
    ) u_ch (
      .clock      (clock),
      .reset      (reset),
      .advance    (advance_s),
      .resync     (resync),
      .load       (load_s),
      .load_div   (cfg_div),
      .load_phase (cfg_phase),
      .en         (en[i]),
      .clk_out    (clk_out[i])
    );
  end

endmodule
